// File: rtl/issue_pkg.sv
// Shared types and sizes for the in-order issue controller.
package issue_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  typedef enum logic [1:0] {
    RUN,
    CTRL_WAIT,
    FLUSH
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never tracked.
module reg_scoreboard
  import issue_pkg::*;
#(
  parameter int unsigned NUM_REGS = issue_pkg::NUM_REGS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_set,
  input  logic [REG_AW-1:0]   i_set_addr,
  input  logic                i_clr,
  input  logic [REG_AW-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (i_clr) busy_d[i_clr_addr] = 1'b0;
    if (i_set) busy_d[i_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: hazard stall, in-flight cap and control-flow serialisation.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int unsigned NUM_REGS     = issue_pkg::NUM_REGS,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_dec_valid,
  output logic                o_dec_ready,
  input  logic [REG_AW-1:0]   i_rs1_addr,
  input  logic [REG_AW-1:0]   i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic [REG_AW-1:0]   i_rd_addr,
  input  logic                i_reg_write,
  input  logic                i_branch,
  input  logic                i_jump,
  input  logic                i_ex_ready,
  output logic                o_issue,
  input  logic                i_reg_write_en,
  input  logic [REG_AW-1:0]   i_reg_write_addr,
  input  logic                i_retire,
  input  logic                i_ctrl_resolved,
  input  logic                i_ctrl_redirect,
  output logic                o_flush,
  output logic [NUM_REGS-1:0] o_busy_regs,
  output logic [CNT_W-1:0]    o_inflight,
  output logic                o_err
);

  logic [NUM_REGS-1:0] busy;
  state_e              state;
  logic [CNT_W-1:0]    inflight;
  logic                flush, err;
  logic                hazard, issue;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set      (issue & i_reg_write),
    .i_set_addr (i_rd_addr),
    .i_clr      (i_reg_write_en),
    .i_clr_addr (i_reg_write_addr),
    .o_busy     (busy)
  );

  // busy[0] is held at 0, so x0 accesses never hazard.
  assign hazard = (i_rs1_used & busy[i_rs1_addr]) |
                  (i_rs2_used & busy[i_rs2_addr]) |
                  (i_reg_write & busy[i_rd_addr]);

  assign issue = i_rst_n & i_dec_valid & (state == RUN) & ~hazard &
                 (inflight < CNT_W'(MAX_INFLIGHT)) & i_ex_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= RUN;
      flush    <= 1'b0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN: begin
          if (issue & (i_branch | i_jump)) state <= CTRL_WAIT;
        end
        CTRL_WAIT: begin
          if (i_ctrl_resolved) begin
            state <= i_ctrl_redirect ? FLUSH : RUN;
            flush <= i_ctrl_redirect;
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase

      if (issue & ~i_retire) begin
        inflight <= inflight + 1'b1;
      end else if (~issue & i_retire & (inflight != '0)) begin
        inflight <= inflight - 1'b1;
      end
      if (i_retire & (inflight == '0)) err <= 1'b1;
    end
  end

  assign o_issue     = issue;
  assign o_dec_ready = issue;
  assign o_flush     = flush;
  assign o_busy_regs = busy;
  assign o_inflight  = inflight;
  assign o_err       = err;

endmodule
